period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_pkg.sv | 13 +
 rtl/sync_rise_detect.sv | 30 +++
 rtl/period_meter.sv | 113 +++++++++++
 tb/tb_period_meter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and default sizing for the period meter.
package period_meter_pkg;

  localparam int DEFAULT_CNT_WIDTH   = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Brings an asynchronous level into the clk domain and flags its rising edges.
module sync_rise_detect
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic level_out,
  output logic rise_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_out = sync_q[SYNC_STAGES-1];
  assign rise_out  = sync_q[SYNC_STAGES-1] & ~s_d;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a square wave between successive rising
// edges and hands the result out through a valid/ready register.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] meas_period,
  output logic [CNT_WIDTH-1:0] meas_high,
  output logic                 meas_valid,
  input  logic                 meas_ready,
  output logic                 meas_overrun,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] period_cnt, high_cnt;
  logic                 s, rise;
  logic                 cnt_load, cnt_inc, result_load;

  sync_rise_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .d_in     (sig_in),
    .level_out(s),
    .rise_out (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Edges out of IDLE or TIMEOUT only restart counting: the period before them is unknown.
  always_comb begin
    state_nxt   = state;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    result_load = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEASURE;
          cnt_load  = 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          cnt_load    = 1'b1;
          result_load = 1'b1;
        end else if (period_cnt == CNT_MAX) begin
          state_nxt = TIMEOUT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      TIMEOUT: begin
        if (rise) begin
          state_nxt = MEASURE;
          cnt_load  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The rise cycle itself has s=1, so both counters restart at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (cnt_load) begin
      period_cnt <= CNT_ONE;
      high_cnt   <= CNT_ONE;
    end else if (cnt_inc) begin
      period_cnt <= period_cnt + CNT_ONE;
      if (s) high_cnt <= high_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= (state_nxt == TIMEOUT);
  end

  // A new result always wins; overrun only when it displaces an unaccepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      meas_period  <= '0;
      meas_high    <= '0;
      meas_valid   <= 1'b0;
      meas_overrun <= 1'b0;
    end else if (result_load) begin
      meas_period  <= period_cnt;
      meas_high    <= high_cnt;
      meas_valid   <= 1'b1;
      meas_overrun <= meas_valid & ~meas_ready;
    end else if (meas_valid && meas_ready) begin
      meas_valid   <= 1'b0;
      meas_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Randomized bench for period_meter: a per-cycle reference model fills a
// scoreboard queue; a separate monitor checks status and accepted results.
module tb_period_meter;

  localparam int W    = 8;
  localparam int SS   = 2;
  localparam int CMAX = (1 << W) - 1;
  localparam int MAXC = 30000;

  logic         clk = 1'b0;
  logic         rst;
  logic         sig_in;
  logic         meas_ready;
  logic [W-1:0] meas_period;
  logic [W-1:0] meas_high;
  logic         meas_valid;
  logic         meas_overrun;
  logic         timeout;

  period_meter #(
    .CNT_WIDTH  (W),
    .SYNC_STAGES(SS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .meas_overrun(meas_overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int high;
    int vis;
  } res_t;

  res_t sbq[$];
  bit   rst_a [MAXC];
  bit   sig_a [MAXC];
  bit   s_a   [MAXC];
  bit   to_a  [MAXC];
  int   cyc = -1;
  int   ph  = 0;
  int   checks = 0;
  int   passes = 0;

  bit   armed = 1'b0;
  bit   tmo   = 1'b0;
  int   last_rise = 0;

  // Reference: level seen by the meter is sig_in delayed SS cycles, forced
  // low while any reset lies in that window; periods are edge-time differences.
  task automatic model_step(input int c);
    bit blocked;
    bit sd;
    bit rise;
    int h;
    blocked = (c < SS);
    for (int k = 1; k <= SS; k++)
      if (c - k >= 0 && rst_a[c-k]) blocked = 1'b1;
    if (blocked) s_a[c] = 1'b0;
    else         s_a[c] = sig_a[c-SS];
    if (c == 0 || rst_a[c-1]) sd = 1'b0;
    else                      sd = s_a[c-1];
    rise = s_a[c] && !sd;
    if (rst_a[c]) begin
      armed = 1'b0;
      tmo   = 1'b0;
    end else if (rise) begin
      if (armed && !tmo) begin
        h = 0;
        for (int x = last_rise; x < c; x++) h += int'(s_a[x]);
        sbq.push_back('{c - last_rise, h, c + 1});
      end
      armed     = 1'b1;
      tmo       = 1'b0;
      last_rise = c;
    end else if (armed && !tmo && (c - last_rise) == CMAX) begin
      tmo = 1'b1;
    end
    to_a[c+1] = tmo;
  endtask

  task automatic tick(input bit r, input bit sg, input bit rd);
    @(posedge clk);
    #1;
    if (cyc + 2 >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    cyc++;
    rst        = r;
    sig_in     = sg;
    meas_ready = rd;
    rst_a[cyc] = r;
    sig_a[cyc] = sg;
    model_step(cyc);
  endtask

  task automatic run(input int n, input int per, input int hi, input int rmode);
    bit rd;
    for (int i = 0; i < n; i++) begin
      if (rmode == 2) rd = 1'($urandom_range(0, 1));
      else            rd = (rmode == 1);
      tick(1'b0, (ph % per) < hi, rd);
      ph++;
    end
  endtask

  // Monitor
  initial begin
    int       n;
    int       c;
    logic [2:0] expv;
    forever begin
      @(negedge clk);
      c = cyc;
      if (c >= 1) begin
        n = 0;
        while (n < sbq.size() && sbq[n].vis <= c) n++;
        expv = {n > 0, n > 1, to_a[c]};
        checks++;
        if ({meas_valid, meas_overrun, timeout} === expv) passes++;
        else $display("FAIL status cyc=%0d valid/overrun/timeout got %b%b%b expected %b",
                      c, meas_valid, meas_overrun, timeout, expv);
        if (rst_a[c-1]) begin
          checks++;
          if (meas_period === '0 && meas_high === '0) passes++;
          else $display("FAIL reset_data cyc=%0d period=%0d high=%0d expected 0/0",
                        c, meas_period, meas_high);
        end
        if (meas_valid === 1'b1 && meas_ready === 1'b1 && n > 0) begin
          checks++;
          if (int'(meas_period) == sbq[n-1].period && int'(meas_high) == sbq[n-1].high) passes++;
          else $display("FAIL result cyc=%0d period=%0d high=%0d expected %0d/%0d",
                        c, meas_period, meas_high, sbq[n-1].period, sbq[n-1].high);
          repeat (n) void'(sbq.pop_front());
        end
        if (rst_a[c]) sbq.delete();
      end
    end
  end

  // Stimulus
  initial begin
    int k, per, hi;
    rst        = 1'b1;
    sig_in     = 1'b1;
    meas_ready = 1'b0;
    // Input high through and after reset: one rise, then timeout, no result.
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    run(300, 1, 1, 2);
    // 10-cycle wave, 4 high, always ready.
    run(70, 10, 4, 1);
    // Consumer stalls 25 cycles: overwrites and overrun, then one accept.
    run(25, 10, 4, 0);
    run(1, 10, 4, 1);
    run(30, 10, 4, 1);
    run(120, 10, 4, 2);
    // Reset six cycles into a period.
    while (ph % 10 != 6) run(1, 10, 4, 1);
    tick(1'b1, 1'b0, 1'b1);
    ph++;
    run(40, 10, 4, 1);
    // Long low: timeout, then recovery and a 20-cycle period.
    run(300, 1000, 0, 1);
    ph = 0;
    run(60, 20, 5, 1);
    // Exact saturation period.
    ph = 0;
    run(CMAX * 3, CMAX, 100, 2);
    // Random segments.
    repeat (40) begin
      k = $urandom_range(0, 9);
      case (k)
        0: run(260 + $urandom_range(0, 40), 1000, 0, 2);
        1: begin ph = 0; run(CMAX * 2 + 3, CMAX, $urandom_range(1, CMAX - 1), 2); end
        2: tick(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        default: begin
          per = $urandom_range(2, 60);
          hi  = $urandom_range(1, per - 1);
          run(per * $urandom_range(2, 5), per, hi, 2);
        end
      endcase
    end
    run(30, 1000, 0, 1);
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
